// File: rtl/isa_io_cycle_sequencer.sv
// ISA I/O bus-cycle master: turns single read/write commands into timed ALE/IOR/IOW cycles with CHRDY wait states.
// Optional read-data passivity checker is built when ISA_PASSIVITY_CHECK_EN is defined.
module isa_io_cycle_sequencer #(
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned ALE_CYCLES      = 10,
    parameter int unsigned SETUP_CYCLES    = 10,
    parameter int unsigned CMD_CYCLES      = 80,
    parameter int unsigned RECOVERY_CYCLES = 4,
    parameter int unsigned CHRDY_TIMEOUT   = 1024
) (
    input  logic                  isa_clk,
    input  logic                  isa_reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [DATA_WIDTH-1:0] cmd_expected,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] isa_addr,
    output logic                  isa_ale,
    output logic                  isa_aen,
    output logic                  isa_ior,
    output logic                  isa_iow,
    output logic [DATA_WIDTH-1:0] isa_data_out,
    output logic                  isa_data_oe,
    input  logic [DATA_WIDTH-1:0] isa_data_in,
    input  logic                  isa_chrdy,
    output logic                  chk_mismatch,
    output logic [15:0]           chk_mismatch_count
);

    localparam int unsigned MAX_AS  = (ALE_CYCLES > SETUP_CYCLES) ? ALE_CYCLES : SETUP_CYCLES;
    localparam int unsigned MAX_CR  = (CMD_CYCLES > RECOVERY_CYCLES) ? CMD_CYCLES : RECOVERY_CYCLES;
    localparam int unsigned MAX_ACR = (MAX_AS > MAX_CR) ? MAX_AS : MAX_CR;
    localparam int unsigned MAX_LEN = (MAX_ACR > CHRDY_TIMEOUT) ? MAX_ACR : CHRDY_TIMEOUT;
    localparam int unsigned CW      = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALE,
        S_SETUP,
        S_CMD,
        S_WAIT,
        S_RECOVER
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  write_q;
    logic                  timed_out;

    logic                  accept_c;
    logic [CW-1:0]         last_cnt_c;
    logic                  phase_done_c;
    logic                  cmd_phase_c;
    logic                  first_recover_c;

    assign accept_c        = (state == S_IDLE) && cmd_ready && cmd_valid;
    assign phase_done_c    = (cnt == last_cnt_c);
    assign cmd_phase_c     = (state == S_CMD) || (state == S_WAIT);
    assign first_recover_c = (state == S_RECOVER) && (cnt == '0);

    // Last counter value of the current phase; WAIT's limit is the CHRDY timeout.
    always_comb begin
        last_cnt_c = '0;
        case (state)
            S_ALE:     last_cnt_c = CW'(ALE_CYCLES - 1);
            S_SETUP:   last_cnt_c = CW'(SETUP_CYCLES - 1);
            S_CMD:     last_cnt_c = CW'(CMD_CYCLES - 1);
            S_WAIT:    last_cnt_c = CW'(CHRDY_TIMEOUT - 1);
            S_RECOVER: last_cnt_c = CW'(RECOVERY_CYCLES - 1);
            default:   last_cnt_c = '0;
        endcase
    end

    // Bus outputs are registered from the current state, so each phase appears one cycle after its state entry.
    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            timed_out    <= 1'b0;
            cmd_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_timeout  <= 1'b0;
            isa_addr     <= '0;
            isa_ale      <= 1'b0;
            isa_aen      <= 1'b0;
            isa_ior      <= 1'b1;
            isa_iow      <= 1'b1;
            isa_data_out <= '0;
            isa_data_oe  <= 1'b0;
        end else begin
            cmd_ready   <= (state == S_IDLE) && !accept_c;
            isa_ale     <= (state == S_ALE);
            isa_aen     <= 1'b0;
            isa_ior     <= !(cmd_phase_c && !write_q);
            isa_iow     <= !(cmd_phase_c && write_q);
            isa_data_oe <= write_q && ((state == S_SETUP) || cmd_phase_c || first_recover_c);
            rsp_valid   <= first_recover_c;
            rsp_timeout <= first_recover_c && timed_out;
            if (state == S_ALE) begin
                isa_addr <= addr_q;
            end
            if ((state == S_SETUP) && write_q) begin
                isa_data_out <= wdata_q;
            end
            cnt <= cnt + CW'(1);

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (accept_c) begin
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        write_q   <= cmd_write;
                        timed_out <= 1'b0;
                        state     <= S_ALE;
                    end
                end
                S_ALE: begin
                    if (phase_done_c) begin
                        cnt   <= '0;
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (phase_done_c) begin
                        cnt   <= '0;
                        state <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (phase_done_c) begin
                        cnt <= '0;
                        if (isa_chrdy) begin
                            if (!write_q) begin
                                rsp_rdata <= isa_data_in;
                            end
                            state <= S_RECOVER;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (isa_chrdy) begin
                        cnt <= '0;
                        if (!write_q) begin
                            rsp_rdata <= isa_data_in;
                        end
                        state <= S_RECOVER;
                    end else if (phase_done_c) begin
                        cnt       <= '0;
                        timed_out <= 1'b1;
                        if (!write_q) begin
                            rsp_rdata <= '0;
                        end
                        state <= S_RECOVER;
                    end
                end
                S_RECOVER: begin
                    if (phase_done_c) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ISA_PASSIVITY_CHECK_EN
    logic [DATA_WIDTH-1:0] expected_q;

    // rsp_rdata was captured on the previous edge, so it is compared on the first RECOVER cycle.
    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            expected_q         <= '0;
            chk_mismatch       <= 1'b0;
            chk_mismatch_count <= '0;
        end else begin
            if (accept_c) begin
                expected_q <= cmd_expected;
            end
            chk_mismatch <= 1'b0;
            if (first_recover_c && !write_q && !timed_out && (rsp_rdata != expected_q)) begin
                chk_mismatch <= 1'b1;
                if (chk_mismatch_count != 16'hFFFF) begin
                    chk_mismatch_count <= chk_mismatch_count + 16'd1;
                end
            end
        end
    end
`else
    logic unused_expected;

    assign unused_expected    = ^cmd_expected;
    assign chk_mismatch       = 1'b0;
    assign chk_mismatch_count = '0;
`endif

endmodule

// File: tb/tb_isa_io_cycle_sequencer.sv
// Directed bench for isa_io_cycle_sequencer at default parameters: phase timing, wait states, timeout, reset abort, checker.
module tb_isa_io_cycle_sequencer;

    logic        isa_clk = 1'b0;
    logic        isa_reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [9:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic [7:0]  cmd_expected;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_timeout;
    logic [9:0]  isa_addr;
    logic        isa_ale;
    logic        isa_aen;
    logic        isa_ior;
    logic        isa_iow;
    logic [7:0]  isa_data_out;
    logic        isa_data_oe;
    logic [7:0]  isa_data_in;
    logic        isa_chrdy;
    logic        chk_mismatch;
    logic [15:0] chk_mismatch_count;

    isa_io_cycle_sequencer dut (
        .isa_clk            (isa_clk),
        .isa_reset          (isa_reset),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_write          (cmd_write),
        .cmd_addr           (cmd_addr),
        .cmd_wdata          (cmd_wdata),
        .cmd_expected       (cmd_expected),
        .rsp_valid          (rsp_valid),
        .rsp_rdata          (rsp_rdata),
        .rsp_timeout        (rsp_timeout),
        .isa_addr           (isa_addr),
        .isa_ale            (isa_ale),
        .isa_aen            (isa_aen),
        .isa_ior            (isa_ior),
        .isa_iow            (isa_iow),
        .isa_data_out       (isa_data_out),
        .isa_data_oe        (isa_data_oe),
        .isa_data_in        (isa_data_in),
        .isa_chrdy          (isa_chrdy),
        .chk_mismatch       (chk_mismatch),
        .chk_mismatch_count (chk_mismatch_count)
    );

    always #5 isa_clk = ~isa_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Edge indices below are counted from the handshake edge (T0).
    int         ale_first, ale_last, ior_first, ior_last, iow_first, iow_last;
    int         oe_first, oe_last, rsp_at, ready_at, mm_pulses, both_low, rel;
    logic [7:0] rdata_seen, dout_seen;
    logic [9:0] addr_seen;
    logic       to_seen, rst_ior, rst_ale, rst_ready, rst_valid;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one command and record the bus activity edge by edge; CHRDY is low on edges [100, 100+zero_len).
    task automatic run_cmd(input logic wr, input logic [9:0] a, input logic [7:0] wd,
                           input logic [7:0] ex, input logic [7:0] din, input int zero_len,
                           input int reset_at, input int limit);
        int  guard;
        bit  done;
        ale_first = -1; ale_last = -1; ior_first = -1; ior_last = -1;
        iow_first = -1; iow_last = -1; oe_first = -1; oe_last = -1;
        rsp_at = -1; ready_at = -1; mm_pulses = 0;
        rdata_seen = 8'hxx; dout_seen = 8'h00; addr_seen = 10'h000; to_seen = 1'b0;
        isa_data_in = din;
        isa_chrdy   = 1'b1;
        guard = 0;
        @(negedge isa_clk);
        while (!cmd_ready && guard < 200) begin
            @(negedge isa_clk);
            guard++;
        end
        check_eq("ready_before_cmd", cmd_ready, 1);
        cmd_valid    = 1'b1;
        cmd_write    = wr;
        cmd_addr     = a;
        cmd_wdata    = wd;
        cmd_expected = ex;
        @(posedge isa_clk);
        rel  = 0;
        done = 1'b0;
        while (!done && rel < limit) begin
            @(negedge isa_clk);
            cmd_valid = 1'b0;
            if (isa_ale)      begin if (ale_first < 0) ale_first = rel; ale_last = rel; end
            if (!isa_ior)     begin if (ior_first < 0) ior_first = rel; ior_last = rel; end
            if (!isa_iow)     begin if (iow_first < 0) iow_first = rel; iow_last = rel; dout_seen = isa_data_out; end
            if (isa_data_oe)  begin if (oe_first < 0) oe_first = rel; oe_last = rel; end
            if (!isa_ior && !isa_iow) both_low++;
            if (rel == 1) addr_seen = isa_addr;
            if (rsp_valid) begin
                rsp_at     = rel;
                rdata_seen = rsp_rdata;
                to_seen    = rsp_timeout;
            end
            if (chk_mismatch) mm_pulses++;
            if (rsp_at >= 0 && cmd_ready && ready_at < 0) begin
                ready_at = rel;
                done     = 1'b1;
            end
            if (rel == reset_at) begin
                isa_reset = 1'b0;
                #1;
                rst_ior   = isa_ior;
                rst_ale   = isa_ale;
                rst_ready = cmd_ready;
                rst_valid = rsp_valid;
            end
            if (rel == reset_at + 3) isa_reset = 1'b1;
            isa_chrdy = !((rel + 1) >= 100 && (rel + 1) < 100 + zero_len);
            rel++;
        end
        isa_chrdy = 1'b1;
    endtask

    initial begin
        int total_mm;
        isa_reset    = 1'b0;
        cmd_valid    = 1'b0;
        cmd_write    = 1'b0;
        cmd_addr     = '0;
        cmd_wdata    = '0;
        cmd_expected = '0;
        isa_data_in  = '0;
        isa_chrdy    = 1'b1;
        both_low     = 0;
        repeat (3) @(negedge isa_clk);
        check_eq("rst_ior", isa_ior, 1);
        check_eq("rst_iow", isa_iow, 1);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_ale", isa_ale, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_oe", isa_data_oe, 0);
        check_eq("rst_mm_count", chk_mismatch_count, 0);
        isa_reset = 1'b1;

        // Basic read, all default timing.
        run_cmd(1'b0, 10'h106, 8'h00, 8'h00, 8'h00, 0, -100, 300);
        check_eq("rd_ale_first", ale_first, 1);
        check_eq("rd_ale_last", ale_last, 10);
        check_eq("rd_ior_first", ior_first, 21);
        check_eq("rd_ior_last", ior_last, 100);
        check_eq("rd_iow_first", iow_first, -1);
        check_eq("rd_rsp_at", rsp_at, 101);
        check_eq("rd_rdata", rdata_seen, 8'h00);
        check_eq("rd_timeout", to_seen, 0);
        check_eq("rd_ready_at", ready_at, 105);
        check_eq("rd_addr", addr_seen, 10'h106);
        check_eq("rd_aen", isa_aen, 0);

        // Read with non-zero data.
        run_cmd(1'b0, 10'h2A5, 8'h00, 8'hA5, 8'hA5, 0, -100, 300);
        check_eq("rd2_rsp_at", rsp_at, 101);
        check_eq("rd2_rdata", rdata_seen, 8'hA5);
        check_eq("rd2_addr", addr_seen, 10'h2A5);

        // Write: IOW timing, data and output-enable window; read data is untouched.
        run_cmd(1'b1, 10'h106, 8'h56, 8'h00, 8'h00, 0, -100, 300);
        check_eq("wr_iow_first", iow_first, 21);
        check_eq("wr_iow_last", iow_last, 100);
        check_eq("wr_ior_first", ior_first, -1);
        check_eq("wr_dout", dout_seen, 8'h56);
        check_eq("wr_oe_first", oe_first, 11);
        check_eq("wr_oe_last", oe_last, 101);
        check_eq("wr_rsp_at", rsp_at, 101);
        check_eq("wr_rdata_held", rdata_seen, 8'hA5);

        // CHRDY low for 7 sampled cycles.
        run_cmd(1'b0, 10'h106, 8'h00, 8'h3C, 8'h3C, 7, -100, 400);
        check_eq("ws_ior_last", ior_last, 107);
        check_eq("ws_rsp_at", rsp_at, 108);
        check_eq("ws_timeout", to_seen, 0);
        check_eq("ws_rdata", rdata_seen, 8'h3C);
        check_eq("ws_ready_at", ready_at, 112);

        // CHRDY stuck low: 10+10+80+1024+1.
        run_cmd(1'b0, 10'h106, 8'h00, 8'h77, 8'h77, 100000, -100, 2000);
        check_eq("to_rsp_at", rsp_at, 1125);
        check_eq("to_ior_last", ior_last, 1124);
        check_eq("to_timeout", to_seen, 1);
        check_eq("to_rdata", rdata_seen, 8'h00);

        // Reset in the middle of a read.
        run_cmd(1'b0, 10'h106, 8'h00, 8'h11, 8'h11, 0, 50, 200);
        check_eq("rsti_ior", rst_ior, 1);
        check_eq("rsti_ale", rst_ale, 0);
        check_eq("rsti_ready", rst_ready, 1);
        check_eq("rsti_valid", rst_valid, 0);
        check_eq("rsti_no_rsp", rsp_at, -1);

        // Full default timing after the aborted cycle.
        run_cmd(1'b0, 10'h106, 8'h00, 8'h00, 8'h00, 0, -100, 300);
        check_eq("post_ale_first", ale_first, 1);
        check_eq("post_ior_first", ior_first, 21);
        check_eq("post_ior_last", ior_last, 100);
        check_eq("post_rsp_at", rsp_at, 101);
        check_eq("post_ready_at", ready_at, 105);

        // Bus driven 8'hFF while 8'h00 is expected.
        total_mm = 0;
        for (int i = 0; i < 5; i++) begin
            run_cmd(1'b0, 10'h106, 8'h00, 8'h00, 8'hFF, 0, -100, 300);
            total_mm += mm_pulses;
        end
        check_eq("chk_rdata", rdata_seen, 8'hFF);
`ifdef ISA_PASSIVITY_CHECK_EN
        check_eq("chk_pulses", total_mm, 5);
        check_eq("chk_count", chk_mismatch_count, 5);
`else
        check_eq("chk_pulses", total_mm, 0);
        check_eq("chk_count", chk_mismatch_count, 0);
`endif
        check_eq("ior_iow_both_low", both_low, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/isa_io_cycle_sequencer.md
# isa_io_cycle_sequencer

Parametrised ISA I/O bus-cycle master that turns single read/write commands into fully timed ALE/IOR/IOW sequences with CHRDY wait-state handling. It drives the ISA side of `sm2201_interface_board` in system benches and on the bring-up FPGA, and generalises the former fixed 8-bit, fixed-timing read model. It adds configurable widths and phase lengths, write cycles, CHRDY timeout detection and an optional bus-passivity data checker.

## Interface
- `ADDR_WIDTH`, default 10: ISA I/O address width.
- `DATA_WIDTH`, default 8: ISA data width (8 or 16).
- `ALE_CYCLES`, default 10: ALE high length, in cycles, ≥1.
- `SETUP_CYCLES`, default 10: cycles from ALE fall to command assert, ≥1.
- `CMD_CYCLES`, default 80: minimum command-low length, ≥1.
- `RECOVERY_CYCLES`, default 4: idle cycles after command release, ≥1.
- `CHRDY_TIMEOUT`, default 1024: maximum wait-state extension, ≥1.

Ports:
- `isa_clk` in 1: single clock, rising edge.
- `isa_reset` in 1: asynchronous reset, active-low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_write` in 1: 1 = write cycle, 0 = read cycle.
- `cmd_addr` in ADDR_WIDTH: I/O address.
- `cmd_wdata` in DATA_WIDTH: write data.
- `cmd_expected` in DATA_WIDTH: expected read data, used by the checker only.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out DATA_WIDTH: captured read data, held until the next read.
- `rsp_timeout` out 1: qualifies `rsp_valid`; the CHRDY timeout expired.
- `isa_addr` out ADDR_WIDTH; `isa_ale` out 1; `isa_aen` out 1 (held 0).
- `isa_ior` out 1; `isa_iow` out 1: both active-low.
- `isa_data_out` out DATA_WIDTH; `isa_data_oe` out 1; `isa_data_in` in DATA_WIDTH.
- `isa_chrdy` in 1: 0 requests wait states.
- `chk_mismatch` out 1: one-cycle pulse with `rsp_valid`.
- `chk_mismatch_count` out 16: saturating mismatch counter.

## Operation
- FSM states: IDLE → ALE → SETUP → CMD → WAIT → RECOVER → IDLE.
- IDLE: `cmd_ready`=1. A handshake (`cmd_valid`&`cmd_ready`) latches addr, write, wdata and expected, then moves to ALE.
- ALE: `isa_addr` is driven from the latched address and `isa_ale`=1 for ALE_CYCLES.
- SETUP: `isa_ale`=0 for SETUP_CYCLES. On writes, `isa_data_out`=wdata and `isa_data_oe`=1 from this state onward.
- CMD: `isa_ior` (read) or `isa_iow` (write) is 0 for CMD_CYCLES.
- At the last CMD cycle:
  - If `isa_chrdy`=1, sample `isa_data_in` (reads).
  - Otherwise enter WAIT, keeping the command low until `isa_chrdy` is sampled 1, then sample.
  - WAIT lasting CHRDY_TIMEOUT cycles sets timeout and releases the command.
- RECOVER:
  - Command released and `rsp_valid` pulses on the first RECOVER cycle.
  - `isa_data_oe` drops after that first cycle.
  - Stay RECOVERY_CYCLES, then return to IDLE.
- A timed-out read returns `rsp_rdata`=0 and `rsp_timeout`=1. Writes never update `rsp_rdata`.
- `isa_addr` holds its last value in IDLE. `cmd_valid` is ignored outside IDLE.
- `isa_ior` and `isa_iow` are never low simultaneously.
- All counters are sized by $clog2 of the largest parameter. The phase counter reloads on every state entry.

## Timing
- Reset values (asynchronous, immediate on `isa_reset`=0):
  - `isa_ior`=`isa_iow`=1; `cmd_ready`=1.
  - All other outputs 0, including the counter.
  - The in-flight cycle is abandoned with no `rsp_valid`.
- Handshake at edge T0 (defaults):
  - ALE high T1–T10; SETUP T11–T20; command low T21–T100.
  - Data sampled at T100 when CHRDY=1.
  - `rsp_valid` and command release at T101; `cmd_ready` returns at T105.
- General form:
  - `rsp_valid` = T0 + ALE + SETUP + CMD + W + 1, where W is the number of wait cycles.
  - Next accept at no earlier than that + RECOVERY_CYCLES.
- `isa_chrdy` is sampled every CMD-last/WAIT cycle. Recovery to 1 in WAIT cycle k gives W=k.

## Configuration
- `ISA_PASSIVITY_CHECK_EN` defined:
  - On each non-timeout read completion, `rsp_rdata`≠expected pulses `chk_mismatch` and increments `chk_mismatch_count`, saturating at 16'hFFFF.
  - Writes and timeouts are never compared.
- Undefined: `chk_mismatch` and `chk_mismatch_count` are tied 0 and `cmd_expected` is unused; no checker logic is built.

## Test plan
- Default parameters, read 10'h106, `isa_data_in`=8'h00, CHRDY=1 → ALE T1–T10, IOR low T21–T100, `rsp_valid` T101, `rsp_rdata`=8'h00, `cmd_ready` T105.
- Write 10'h106 data 8'h56 → IOW low T21–T100, `isa_data_out`=8'h56, `isa_data_oe` high T11–T101, IOR stays 1.
- Read with CHRDY held 0 for 7 cycles → IOR low through T107, `rsp_valid` T108, `rsp_timeout`=0.
- CHRDY stuck 0, CHRDY_TIMEOUT=16 → `rsp_valid` with `rsp_timeout`=1, `rsp_rdata`=0.
- CHECK_EN, 5 reads of 10'h106, expected 8'h00, bus driven 8'hFF → 5 `chk_mismatch` pulses, count=5.
- Reset asserted at T50 of a read → IOR=1, ALE=0 and `cmd_ready`=1 immediately, no `rsp_valid`; the next command runs the full default timing.
